// File: rtl/beta_ctrl_pkg.sv
// Shared encodings for the Beta multi-cycle control unit: opcodes, ALU
// function codes, FSM states and datapath select values.
package beta_ctrl_pkg;

  localparam logic [5:0] OP_LD  = 6'h18;
  localparam logic [5:0] OP_ST  = 6'h19;
  localparam logic [5:0] OP_JMP = 6'h1B;
  localparam logic [5:0] OP_BEQ = 6'h1C;
  localparam logic [5:0] OP_BNE = 6'h1D;
  localparam logic [5:0] OP_LDR = 6'h1F;

  localparam logic [5:0] ALUFN_ADD   = 6'b100000;
  localparam logic [5:0] ALUFN_SUB   = 6'b100001;
  localparam logic [5:0] ALUFN_CMPEQ = 6'b100100;
  localparam logic [5:0] ALUFN_CMPLT = 6'b100101;
  localparam logic [5:0] ALUFN_CMPLE = 6'b100110;
  localparam logic [5:0] ALUFN_AND   = 6'b101000;
  localparam logic [5:0] ALUFN_OR    = 6'b101001;
  localparam logic [5:0] ALUFN_XOR   = 6'b101010;
  localparam logic [5:0] ALUFN_XNOR  = 6'b101011;
  localparam logic [5:0] ALUFN_SHL   = 6'b101100;
  localparam logic [5:0] ALUFN_SHR   = 6'b101101;
  localparam logic [5:0] ALUFN_SRA   = 6'b101110;
  localparam logic [5:0] ALUFN_PASSA = 6'b111111;

  localparam logic [2:0] PCSEL_INC   = 3'd0;
  localparam logic [2:0] PCSEL_BR    = 3'd1;
  localparam logic [2:0] PCSEL_JMP   = 3'd2;
  localparam logic [2:0] PCSEL_ILLOP = 3'd3;

  localparam logic [1:0] WDSEL_PC  = 2'd0;
  localparam logic [1:0] WDSEL_ALU = 2'd1;
  localparam logic [1:0] WDSEL_MEM = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  typedef enum logic [1:0] {
    BR_NONE,
    BR_BEQ,
    BR_BNE,
    BR_JMP
  } br_t;

  typedef struct packed {
    logic [5:0] alufn;
    logic       asel;
    logic       bsel;
    logic       ra2sel;
    logic [1:0] wdsel;
    logic       mem;
    logic       st;
    br_t        br;
  } ctrl_t;

  // Low nibbles 2, 3, 7 and F have no ALU function behind them.
  function automatic logic alu_fn_legal(input logic [3:0] fn);
    return !(fn == 4'h2 || fn == 4'h3 || fn == 4'h7 || fn == 4'hF);
  endfunction

endpackage

// File: rtl/beta_opcode_decoder.sv
// Purely combinational opcode decoder: maps a 6-bit Beta opcode to the
// datapath control bundle and flags opcodes that must trap.
module beta_opcode_decoder
  import beta_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output ctrl_t      ctrl,
  output logic       illegal
);

  always_comb begin
    ctrl       = '0;
    ctrl.alufn = ALUFN_PASSA;
    ctrl.wdsel = WDSEL_PC;
    ctrl.br    = BR_NONE;
    illegal    = 1'b0;
    // 0x20-0x2F register forms and 0x30-0x3F constant forms share one encoding.
    if (opcode[5]) begin
      if (alu_fn_legal(opcode[3:0])) begin
        ctrl.alufn = {opcode[5], 1'b0, opcode[3:0]};
        ctrl.bsel  = opcode[4];
        ctrl.wdsel = WDSEL_ALU;
      end else begin
        illegal = 1'b1;
      end
    end else begin
      case (opcode)
        OP_LD: begin
          ctrl.alufn = ALUFN_ADD;
          ctrl.bsel  = 1'b1;
          ctrl.wdsel = WDSEL_MEM;
          ctrl.mem   = 1'b1;
        end
        OP_ST: begin
          ctrl.alufn  = ALUFN_ADD;
          ctrl.bsel   = 1'b1;
          ctrl.ra2sel = 1'b1;
          ctrl.wdsel  = WDSEL_ALU;
          ctrl.mem    = 1'b1;
          ctrl.st     = 1'b1;
        end
        OP_LDR: begin
          ctrl.alufn = ALUFN_PASSA;
          ctrl.asel  = 1'b1;
          ctrl.wdsel = WDSEL_MEM;
          ctrl.mem   = 1'b1;
        end
        OP_JMP:  ctrl.br = BR_JMP;
        OP_BEQ:  ctrl.br = BR_BEQ;
        OP_BNE:  ctrl.br = BR_BNE;
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/beta_ctrl_fsm.sv
// Multi-cycle control FSM for the unpipelined Beta core: fetch, decode,
// execute, optional data-memory access, write-back, and illegal-op trap.
module beta_ctrl_fsm
  import beta_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned XP_REG      = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] instr,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  input  logic        z,
  output logic [5:0]  alufn,
  output logic        asel,
  output logic        bsel,
  output logic        ra2sel,
  output logic        wasel,
  output logic [1:0]  wdsel,
  output logic        werf,
  output logic [2:0]  pcsel,
  output logic        pc_en,
  output logic [31:0] ir,
  output logic        illop
);

  localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LIM_C =
    CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  if (XP_REG > 31) begin : g_xp_range
    $error("XP_REG must name one of the 32 registers");
  end

  state_t           state, next_state;
  ctrl_t            ctrl;
  logic             illegal;
  logic             live;
  logic [CNT_W-1:0] wcnt;
  logic             expire;
  logic [1:0]       wdsel_q;
  logic [2:0]       pcsel_q;
  logic [2:0]       br_sel;

  beta_opcode_decoder u_dec (
    .opcode  (ir[31:26]),
    .ctrl    (ctrl),
    .illegal (illegal)
  );

  assign expire = (MEM_TIMEOUT != 0) && (wcnt == LIM_C);

  // live holds off the first fetch request until reset has been released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      live  <= 1'b0;
      wcnt  <= '0;
    end else begin
      state <= next_state;
      live  <= 1'b1;
      if ((state == S_FETCH && live) || state == S_MEM) begin
        wcnt <= wcnt + CNT_W'(1);
      end else begin
        wcnt <= '0;
      end
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_FETCH: begin
        if (live) begin
          if (imem_ack)    next_state = S_DECODE;
          else if (expire) next_state = S_TRAP;
        end
      end
      S_DECODE: next_state = illegal ? S_TRAP : S_EXEC;
      S_EXEC:   next_state = ctrl.mem ? S_MEM : S_WB;
      S_MEM: begin
        if (dmem_ack)    next_state = S_WB;
        else if (expire) next_state = S_TRAP;
      end
      S_WB:     next_state = S_FETCH;
      S_TRAP:   next_state = S_FETCH;
      default:  next_state = S_FETCH;
    endcase
  end

  always_comb begin
    br_sel = PCSEL_INC;
    unique case (ctrl.br)
      BR_BEQ:  br_sel = z ? PCSEL_BR : PCSEL_INC;
      BR_BNE:  br_sel = z ? PCSEL_INC : PCSEL_BR;
      BR_JMP:  br_sel = PCSEL_JMP;
      default: br_sel = PCSEL_INC;
    endcase
  end

  // Decoded selects are held from DECODE until the next DECODE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir      <= '0;
      alufn   <= ALUFN_PASSA;
      asel    <= 1'b0;
      bsel    <= 1'b0;
      ra2sel  <= 1'b0;
      wdsel_q <= WDSEL_PC;
      pcsel_q <= PCSEL_INC;
    end else begin
      if (state == S_FETCH && live && imem_ack) begin
        ir <= instr;
      end
      if (state == S_DECODE && !illegal) begin
        alufn   <= ctrl.alufn;
        asel    <= ctrl.asel;
        bsel    <= ctrl.bsel;
        ra2sel  <= ctrl.ra2sel;
        wdsel_q <= ctrl.wdsel;
      end
      if (state == S_EXEC) begin
        pcsel_q <= br_sel;
      end
    end
  end

  always_comb begin
    imem_req = (state == S_FETCH) && live;
    dmem_req = (state == S_MEM);
    dmem_we  = (state == S_MEM) && ctrl.st;
    werf     = ((state == S_WB) && !ctrl.st) || (state == S_TRAP);
    pc_en    = (state == S_WB) || (state == S_TRAP);
    illop    = (state == S_TRAP);
    wasel    = (state == S_TRAP);
    pcsel    = (state == S_TRAP) ? PCSEL_ILLOP : pcsel_q;
    wdsel    = (state == S_TRAP) ? WDSEL_PC : wdsel_q;
  end

endmodule

// File: tb/tb_beta_ctrl_fsm.sv
// Directed bench for beta_ctrl_fsm: each instruction is run to completion and
// its observed pulses, selects and latency are compared with hand-derived values.
module tb_beta_ctrl_fsm;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] instr;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        z;
  logic [5:0]  alufn;
  logic        asel;
  logic        bsel;
  logic        ra2sel;
  logic        wasel;
  logic [1:0]  wdsel;
  logic        werf;
  logic [2:0]  pcsel;
  logic        pc_en;
  logic [31:0] ir;
  logic        illop;

  int n_chk;
  int n_fail;

  int          lat, ireq_n, werf_n, pcen_n, illop_n, dreq_n, dwe_n;
  logic [5:0]  c_alufn;
  logic        c_asel, c_bsel, c_ra2sel, c_wasel;
  logic [2:0]  c_pcsel;
  logic [1:0]  c_wdsel;
  logic [31:0] c_ir;

  beta_ctrl_fsm #(.MEM_TIMEOUT(4), .XP_REG(30)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .imem_req (imem_req),
    .imem_ack (imem_ack),
    .instr    (instr),
    .dmem_req (dmem_req),
    .dmem_we  (dmem_we),
    .dmem_ack (dmem_ack),
    .z        (z),
    .alufn    (alufn),
    .asel     (asel),
    .bsel     (bsel),
    .ra2sel   (ra2sel),
    .wasel    (wasel),
    .wdsel    (wdsel),
    .werf     (werf),
    .pcsel    (pcsel),
    .pc_en    (pc_en),
    .ir       (ir),
    .illop    (illop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ctl_vec();
    return {imem_req, dmem_req, dmem_we, asel, bsel, ra2sel, wasel,
            werf, pc_en, illop, pcsel, wdsel};
  endfunction

  task automatic fetch(input logic [31:0] w, input int iw);
    ireq_n = 0;
    for (int k = 0; k < 40; k++) begin
      if (imem_req !== 1'b1) break;
      ireq_n++;
      if (ireq_n == iw + 1) begin
        imem_ack = 1'b1;
        instr    = w;
      end
      tick;
      imem_ack = 1'b0;
      instr    = 32'hDEAD_BEEF;
    end
  endtask

  task automatic run(input logic [31:0] w, input int iw, input int dw, input logic zz);
    z = zz;
    fetch(w, iw);
    lat = ireq_n;
    werf_n = 0; pcen_n = 0; illop_n = 0; dreq_n = 0; dwe_n = 0;
    c_alufn = 'x; c_asel = 'x; c_bsel = 'x; c_ra2sel = 'x;
    c_pcsel = 'x; c_wdsel = 'x; c_wasel = 'x; c_ir = 'x;
    for (int k = 0; k < 40; k++) begin
      if (imem_req === 1'b1) break;
      lat++;
      if (k == 0) c_ir = ir;
      if (k == 1) begin
        c_alufn = alufn; c_asel = asel; c_bsel = bsel; c_ra2sel = ra2sel;
      end
      werf_n  += int'(werf);
      pcen_n  += int'(pc_en);
      illop_n += int'(illop);
      if (dmem_req === 1'b1) begin
        dreq_n++;
        dwe_n += int'(dmem_we);
        if (dreq_n == dw + 1) dmem_ack = 1'b1;
      end
      if (pc_en === 1'b1) begin
        c_pcsel = pcsel; c_wdsel = wdsel; c_wasel = wasel;
      end
      tick;
      dmem_ack = 1'b0;
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; imem_ack = 1'b0; instr = '0; dmem_ack = 1'b0; z = 1'b0;
    tick; tick;
    check("rst_ctl", ctl_vec(), 16'h0);
    check("rst_alufn", alufn, 6'h3F);
    check("rst_ir", ir, 32'h0);
    rst_n = 1'b1;
    tick;
    check("start_ireq", imem_req, 1'b1);

    // ADDC, zero-wait fetch
    run(32'hC022_0005, 0, 0, 1'b0);
    check("addc_ireq", ireq_n, 1);
    check("addc_ir", c_ir, 32'hC022_0005);
    check("addc_alufn", c_alufn, 6'b100000);
    check("addc_bsel", c_bsel, 1'b1);
    check("addc_werf", werf_n, 1);
    check("addc_wdsel", c_wdsel, 2'd1);
    check("addc_pcen", pcen_n, 1);
    check("addc_pcsel", c_pcsel, 3'd0);
    check("addc_lat", lat, 4);

    // SUB, fetch ack on the last cycle before the timeout
    run(32'h8420_1800, 3, 0, 1'b0);
    check("sub_ireq", ireq_n, 4);
    check("sub_alufn", c_alufn, 6'b100001);
    check("sub_bsel", c_bsel, 1'b0);
    check("sub_werf", werf_n, 1);
    check("sub_illop", illop_n, 0);
    check("sub_lat", lat, 7);

    // ST with two data wait cycles
    run(32'h6441_0004, 0, 2, 1'b0);
    check("st_dreq", dreq_n, 3);
    check("st_dwe", dwe_n, 3);
    check("st_ra2sel", c_ra2sel, 1'b1);
    check("st_alufn", c_alufn, 6'b100000);
    check("st_werf", werf_n, 0);
    check("st_pcen", pcen_n, 1);
    check("st_lat", lat, 7);

    // LD and LDR
    run(32'h6041_0008, 0, 0, 1'b0);
    check("ld_wdsel", c_wdsel, 2'd2);
    check("ld_dwe", dwe_n, 0);
    check("ld_werf", werf_n, 1);
    check("ld_lat", lat, 5);
    run(32'h7C20_0010, 0, 0, 1'b0);
    check("ldr_asel", c_asel, 1'b1);
    check("ldr_alufn", c_alufn, 6'b111111);
    check("ldr_wdsel", c_wdsel, 2'd2);

    // Branches and jump
    run(32'h7020_0003, 0, 0, 1'b1);
    check("beq_t_pcsel", c_pcsel, 3'd1);
    check("beq_t_werf", werf_n, 1);
    check("beq_t_wdsel", c_wdsel, 2'd0);
    check("beq_t_lat", lat, 4);
    run(32'h7020_0003, 0, 0, 1'b0);
    check("beq_n_pcsel", c_pcsel, 3'd0);
    check("beq_n_werf", werf_n, 1);
    check("beq_n_wdsel", c_wdsel, 2'd0);
    run(32'h7420_0003, 0, 0, 1'b0);
    check("bne_t_pcsel", c_pcsel, 3'd1);
    run(32'h6C20_0000, 0, 0, 1'b0);
    check("jmp_pcsel", c_pcsel, 3'd2);

    // Illegal opcodes
    run(32'h0000_0000, 0, 0, 1'b0);
    check("ill0_illop", illop_n, 1);
    check("ill0_pcsel", c_pcsel, 3'd3);
    check("ill0_wasel", c_wasel, 1'b1);
    check("ill0_werf", werf_n, 1);
    check("ill0_wdsel", c_wdsel, 2'd0);
    check("ill0_lat", lat, 3);
    run(32'h8800_0000, 0, 0, 1'b0);
    check("ill22_illop", illop_n, 1);
    run(32'hFC00_0000, 0, 0, 1'b0);
    check("ill3f_illop", illop_n, 1);

    // LD whose data ack never comes
    run(32'h6041_0008, 0, 1000, 1'b0);
    check("tmo_dreq", dreq_n, 4);
    check("tmo_illop", illop_n, 1);
    check("tmo_pcsel", c_pcsel, 3'd3);
    check("tmo_wdsel", c_wdsel, 2'd0);
    check("tmo_lat", lat, 8);

    // Asynchronous reset in the middle of a store
    fetch(32'h6441_0004, 0);
    tick;
    tick;
    check("mid_dreq", dmem_req, 1'b1);
    check("mid_dwe", dmem_we, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ctl", ctl_vec(), 16'h0);
    check("arst_alufn", alufn, 6'h3F);
    check("arst_ir", ir, 32'h0);
    tick;
    rst_n = 1'b1;
    tick;
    check("rec_ireq", imem_req, 1'b1);
    run(32'h8020_0800, 0, 0, 1'b0);
    check("rec_alufn", c_alufn, 6'b100000);
    check("rec_werf", werf_n, 1);
    check("rec_lat", lat, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
